// File: rtl/multicore_pkg.sv
// Shared widths for the multicore fetch path.
package multicore_pkg;
  localparam int unsigned INST_SIZE = 32;
endpackage

// File: rtl/imem_responder.sv
// imem_responder: single-ported instruction memory answering the fetch
// request handshake, with configurable wait states and a host write port.
//
// Ports:
//   i_aclk, i_areset_n           clock, async active-low reset
//   i_req / o_req_ready, i_addr  request handshake and byte address
//   o_instr_valid, o_instruction one-cycle response pulse and held data word
//   i_wr_en, i_wr_addr, i_wr_data host preload/patch port
//   o_fault, o_fault_addr        bad-address reporting
//
// Build option: define IMEM_FAULT_EN to enable fault reporting; otherwise
// o_fault/o_fault_addr are tied low and bad reads just return a NOP.
module imem_responder #(
  parameter int unsigned          ADDR_SIZE   = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = '0,
  parameter int unsigned          DEPTH       = 4096,
  parameter int unsigned          WAIT_STATES = 0,
  parameter string                INIT_FILE   = ""
) (
  input  logic                             i_aclk,
  input  logic                             i_areset_n,
  input  logic                             i_req,
  output logic                             o_req_ready,
  input  logic [ADDR_SIZE-1:0]             i_addr,
  output logic                             o_instr_valid,
  output logic [multicore_pkg::INST_SIZE-1:0] o_instruction,
  input  logic                             i_wr_en,
  input  logic [ADDR_SIZE-1:0]             i_wr_addr,
  input  logic [multicore_pkg::INST_SIZE-1:0] i_wr_data,
  output logic                             o_fault,
  output logic [ADDR_SIZE-1:0]             o_fault_addr
);
  localparam int unsigned INST_SIZE = multicore_pkg::INST_SIZE;
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned WRD_W     = ADDR_SIZE - 2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WS_LOAD   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [INST_SIZE-1:0] NOP = INST_SIZE'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [INST_SIZE-1:0] r_mem [DEPTH];

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_req_ready;
  logic                 r_instr_valid;
  logic [INST_SIZE-1:0] r_instruction;
  logic [INST_SIZE-1:0] r_rd_data;

  // Word-granular offset from BASE_ADDR; the extra MSB is the borrow that
  // flags addresses below the base.
  logic [WRD_W:0]       w_rd_diff;
  logic [WRD_W:0]       w_wr_diff;
  logic                 w_rd_bad;
  logic                 w_wr_bad;
  logic                 w_accept;
  logic [INST_SIZE-1:0] w_rd_word;

  assign w_rd_diff = {1'b0, i_addr[ADDR_SIZE-1:2]}    - {1'b0, BASE_ADDR[ADDR_SIZE-1:2]};
  assign w_wr_diff = {1'b0, i_wr_addr[ADDR_SIZE-1:2]} - {1'b0, BASE_ADDR[ADDR_SIZE-1:2]};

  assign w_rd_bad = (i_addr[1:0] != 2'b00) || w_rd_diff[WRD_W] ||
                    (w_rd_diff[WRD_W-1:IDX_W] != '0);
  assign w_wr_bad = (i_wr_addr[1:0] != 2'b00) || w_wr_diff[WRD_W] ||
                    (w_wr_diff[WRD_W-1:IDX_W] != '0);

  assign w_accept  = i_req && r_req_ready;
  assign w_rd_word = w_rd_bad ? NOP : r_mem[w_rd_diff[IDX_W-1:0]];

  // Host write port; bad addresses are dropped.
  always_ff @(posedge i_aclk) begin
    if (i_wr_en && !w_wr_bad) r_mem[w_wr_diff[IDX_W-1:0]] <= i_wr_data;
  end

  // Request FSM; the memory word is sampled at the acceptance edge.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_req_ready   <= 1'b1;
      r_instr_valid <= 1'b0;
      r_instruction <= '0;
      r_rd_data     <= '0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            if (WAIT_STATES == 0) begin
              r_state       <= S_RESP;
              r_req_ready   <= 1'b1;
              r_instr_valid <= 1'b1;
              r_instruction <= w_rd_word;
            end else begin
              r_state     <= S_WAIT;
              r_req_ready <= 1'b0;
              r_cnt       <= CNT_W'(WS_LOAD);
              r_rd_data   <= w_rd_word;
            end
          end else begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state       <= S_RESP;
            r_req_ready   <= 1'b1;
            r_instr_valid <= 1'b1;
            r_instruction <= r_rd_data;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_instr_valid = r_instr_valid;
  assign o_instruction = r_instruction;

`ifdef IMEM_FAULT_EN
  logic                 r_rd_bad;
  logic                 r_fault;
  logic [ADDR_SIZE-1:0] r_fault_addr;
  logic                 w_resp_fire;
  logic                 w_resp_bad;

  // Edge at which a response is launched, and whether it is a bad one.
  assign w_resp_fire = (WAIT_STATES == 0) ? w_accept : ((r_state == S_WAIT) && (r_cnt == '0));
  assign w_resp_bad  = (WAIT_STATES == 0) ? w_rd_bad : r_rd_bad;

  // Fault pulse and address; a read fault owns the address over a write fault.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_rd_bad     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_fault <= (w_resp_fire && w_resp_bad) || (i_wr_en && w_wr_bad);
      if (w_accept) r_rd_bad <= w_rd_bad;
      if (w_accept && w_rd_bad) begin
        r_fault_addr <= i_addr;
      end else if (i_wr_en && w_wr_bad && !(w_resp_fire && w_resp_bad)) begin
        r_fault_addr <= i_wr_addr;
      end
    end
  end

  assign o_fault      = r_fault;
  assign o_fault_addr = r_fault_addr;
`else
  assign o_fault      = 1'b0;
  assign o_fault_addr = '0;
`endif

endmodule
